btn_debounce: RTL and testbench

Input conditioner for the up-down counter board. It synchronises N_BTN raw push-button/switch inputs, debounces each one independently with a per-channel counter FSM, and produces a clean level plus one-cycle rise/fall pulses per channel. Channel 0 level drives the counter's `down` input; the channel 1 rise pulse drives the counter's clear. The block sits directly upstream of the counter, between the board pins and the counting logic.

---
 rtl/btn_debounce_pkg.sv | 15 +
 rtl/btn_debounce_if.sv | 28 ++
 rtl/btn_debounce_ch.sv | 100 ++++++++++
 rtl/btn_debounce.sv | 41 ++++
 tb/tb_btn_debounce.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared types and constants for the push-button input conditioner.
package btn_debounce_pkg;

   // Per-channel debounce FSM: stable levels plus one arming state per direction.
   typedef enum logic [1:0] {
      LOW    = 2'd0,
      ARM_HI = 2'd1,
      HIGH   = 2'd2,
      ARM_LO = 2'd3
   } db_state_e;

   localparam int CH_DOWN = 0;
   localparam int CH_CLR  = 1;

endpackage

// File: rtl/btn_debounce_if.sv
// Bundle between the board pins and the counter: raw buttons in, clean levels/pulses out.
interface btn_debounce_if #(
   parameter int N_BTN = 2
);
   // There is no valid/ready pairing: btn_raw is a free-running level sampled on every
   // rising clock edge, and every output is a registered level or a one-cycle pulse.
   logic [N_BTN-1:0]   btn_raw;
   logic [N_BTN-1:0]   btn_level;
   logic [N_BTN-1:0]   btn_rise;
   logic [N_BTN-1:0]   btn_fall;
   logic [2*N_BTN-1:0] dbg_state;

   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_rise,
      input  btn_fall,
      input  dbg_state
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_rise,
      output btn_fall,
      output dbg_state
   );
endinterface

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability-counting FSM, registered outputs.
module btn_debounce_ch
   import btn_debounce_pkg::*;
#(
   parameter int DB_CYCLES = 16
) (
   input  logic      clk,
   input  logic      res,
   input  logic      raw,
   output logic      level,
   output logic      rise,
   output logic      fall,
   output db_state_e state
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);

   logic             meta;
   logic             sync;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             cnt_done;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= raw;
         sync <= meta;
      end
   end

   // cnt is cleared on every state exit, so cnt_inc never passes DB_CYCLES.
   assign cnt_inc  = cnt + CNT_W'(1);
   assign cnt_done = (cnt_inc == CNT_W'(DB_CYCLES));

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state <= LOW;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            LOW: begin
               if (sync) begin
                  state <= ARM_HI;
                  cnt   <= CNT_W'(1);
               end
            end
            ARM_HI: begin
               if (!sync) begin
                  state <= LOW;
                  cnt   <= '0;
               end else if (cnt_done) begin
                  state <= HIGH;
                  cnt   <= '0;
                  level <= 1'b1;
                  rise  <= 1'b1;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            HIGH: begin
               if (!sync) begin
                  state <= ARM_LO;
                  cnt   <= CNT_W'(1);
               end
            end
            ARM_LO: begin
               if (sync) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else if (cnt_done) begin
                  state <= LOW;
                  cnt   <= '0;
                  level <= 1'b0;
                  fall  <= 1'b1;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state <= LOW;
               cnt   <= '0;
            end
         endcase
      end
   end

   a_no_rise_and_fall: assert property (@(posedge clk) disable iff (!res) !(rise && fall));
   a_rise_one_cycle:   assert property (@(posedge clk) disable iff (!res) rise |=> !rise);
   a_fall_one_cycle:   assert property (@(posedge clk) disable iff (!res) fall |=> !fall);
   a_cnt_bounded:      assert property (@(posedge clk) disable iff (!res) cnt <= CNT_W'(DB_CYCLES));

endmodule

// File: rtl/btn_debounce.sv
// N_BTN independent debounce channels feeding the up-down counter's down/clear inputs.
module btn_debounce
   import btn_debounce_pkg::*;
#(
   parameter int N_BTN     = 2,
   parameter int DB_CYCLES = 16
) (
   input logic            clk,
   input logic            res,
   btn_debounce_if.slave  bus
);

   logic [N_BTN-1:0]   level_v;
   logic [N_BTN-1:0]   rise_v;
   logic [N_BTN-1:0]   fall_v;
   logic [2*N_BTN-1:0] state_v;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      db_state_e st;

      btn_debounce_ch #(
         .DB_CYCLES (DB_CYCLES)
      ) u_ch (
         .clk   (clk),
         .res   (res),
         .raw   (bus.btn_raw[i]),
         .level (level_v[i]),
         .rise  (rise_v[i]),
         .fall  (fall_v[i]),
         .state (st)
      );

      assign state_v[2*i +: 2] = st;
   end

   assign bus.btn_level = level_v;
   assign bus.btn_rise  = rise_v;
   assign bus.btn_fall  = fall_v;
   assign bus.dbg_state = state_v;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with DB_CYCLES=4: vector table, reset sequences, random model run.
module tb_btn_debounce;

   localparam int N  = 2;
   localparam int DB = 4;

   typedef struct packed {
      logic [1:0] raw;
      logic [5:0] exp;   // {level, rise, fall}
   } vec_t;

   logic clk = 1'b0;
   logic res = 1'b0;

   btn_debounce_if #(.N_BTN(N)) bus ();

   btn_debounce #(
      .N_BTN     (N),
      .DB_CYCLES (DB)
   ) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   always #25 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [5:0] exp_q[$];
   vec_t       vecs[$];

   // Reference model: per-channel history of synchronised samples.
   logic [1:0]    m_meta;
   logic [1:0]    m_sync;
   logic [1:0]    m_lvl;
   logic [DB-1:0] m_hist[N];

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
      end
   endtask

   task automatic step(input logic [1:0] raw, input logic [5:0] exp, input string name);
      logic [5:0] want;
      bus.btn_raw = raw;
      exp_q.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      want = exp_q.pop_front();
      check(name, {2'b00, bus.btn_level, bus.btn_rise, bus.btn_fall}, {2'b00, want});
   endtask

   task automatic add(input logic [1:0] raw, input logic [1:0] l, input logic [1:0] r,
                      input logic [1:0] f, input int n);
      vec_t v;
      v.raw = raw;
      v.exp = {l, r, f};
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic model_reset();
      m_meta = '0;
      m_sync = '0;
      m_lvl  = '0;
      for (int c = 0; c < N; c++) m_hist[c] = '0;
   endtask

   task automatic model_edge(input logic [1:0] raw, output logic [5:0] exp);
      logic [1:0] rs;
      logic [1:0] fs;
      rs = '0;
      fs = '0;
      for (int c = 0; c < N; c++) begin
         m_hist[c] = {m_hist[c][DB-2:0], m_sync[c]};
         if (m_hist[c] == {DB{~m_lvl[c]}}) begin
            m_lvl[c] = ~m_lvl[c];
            rs[c]    = m_lvl[c];
            fs[c]    = ~m_lvl[c];
         end
      end
      m_sync = m_meta;
      m_meta = raw;
      exp = {m_lvl, rs, fs};
   endtask

   task automatic check_zero(input string name);
      check(name, {bus.dbg_state[3:0], bus.btn_level, bus.btn_rise, bus.btn_fall}, 8'h00);
   endtask

   initial begin
      logic [5:0] e;
      logic [1:0] r;
      int         left[N];

      bus.btn_raw = '0;
      model_reset();

      // Short pulse on ch1, then clean press / release / bounce / release on ch0.
      add(2'b10, 2'b00, 2'b00, 2'b00, 3);
      add(2'b00, 2'b00, 2'b00, 2'b00, 5);
      add(2'b01, 2'b00, 2'b00, 2'b00, 5);
      add(2'b01, 2'b01, 2'b01, 2'b00, 1);
      add(2'b01, 2'b01, 2'b00, 2'b00, 2);
      add(2'b00, 2'b01, 2'b00, 2'b00, 5);
      add(2'b00, 2'b00, 2'b00, 2'b01, 1);
      add(2'b00, 2'b00, 2'b00, 2'b00, 2);
      add(2'b01, 2'b00, 2'b00, 2'b00, 3);
      add(2'b00, 2'b00, 2'b00, 2'b00, 1);
      add(2'b01, 2'b00, 2'b00, 2'b00, 5);
      add(2'b01, 2'b01, 2'b01, 2'b00, 1);
      add(2'b01, 2'b01, 2'b00, 2'b00, 2);
      add(2'b00, 2'b01, 2'b00, 2'b00, 5);
      add(2'b00, 2'b00, 2'b00, 2'b01, 1);
      add(2'b00, 2'b00, 2'b00, 2'b00, 2);
      // Both channels together, then ch0 release while ch1 glitches low for 2 cycles.
      add(2'b11, 2'b00, 2'b00, 2'b00, 5);
      add(2'b11, 2'b11, 2'b11, 2'b00, 1);
      add(2'b11, 2'b11, 2'b00, 2'b00, 2);
      add(2'b10, 2'b11, 2'b00, 2'b00, 2);
      add(2'b00, 2'b11, 2'b00, 2'b00, 2);
      add(2'b10, 2'b11, 2'b00, 2'b00, 1);
      add(2'b10, 2'b10, 2'b00, 2'b01, 1);
      add(2'b10, 2'b10, 2'b00, 2'b00, 3);
      add(2'b11, 2'b10, 2'b00, 2'b00, 5);
      add(2'b11, 2'b11, 2'b01, 2'b00, 1);
      add(2'b11, 2'b11, 2'b00, 2'b00, 2);

      @(negedge clk);
      @(negedge clk);
      check_zero("reset_state");
      res = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].raw, vecs[i].exp, $sformatf("vec[%0d]", i));
      end

      // Asynchronous reset while both levels are high: no fall pulse, outputs clear at once.
      #10 res = 1'b0;
      #1 check_zero("async_reset");
      @(negedge clk);
      check_zero("in_reset_1");
      @(negedge clk);
      check_zero("in_reset_2");
      res = 1'b1;
      for (int i = 0; i < 5; i++) step(2'b11, 6'b00_00_00, "post_rst_wait");
      step(2'b11, 6'b11_11_00, "post_rst_rise");
      step(2'b11, 6'b11_00_00, "post_rst_hold");

      bus.btn_raw = '0;
      res = 1'b0;
      @(negedge clk);
      check_zero("rand_reset");
      res = 1'b1;
      model_reset();

      for (int c = 0; c < N; c++) left[c] = 0;
      r = '0;
      for (int k = 0; k < 600; k++) begin
         for (int c = 0; c < N; c++) begin
            if (left[c] == 0) begin
               r[c]    = 1'($urandom_range(0, 1));
               left[c] = $urandom_range(1, 7);
            end
            left[c]--;
         end
         model_edge(r, e);
         step(r, e, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
